// File: rtl/imem_resp_32_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_resp_32_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] DEFAULT_WORD = 32'h00000000;
  localparam int FIFO_DEPTH_DEF = 4;

  // Pointer carries one extra bit so full and empty differ only in the MSB.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = fifo_ptr_w(FIFO_DEPTH_DEF);

  typedef struct packed {
    logic               err;
    logic [INSTR_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/imem_resp_32_if.sv
// Fetch request/response and program-load bundle between fetch unit and imem.
// Latency: n/a (wires only).
// Backpressure: req_ready/rsp_ready carry the valid-ready handshakes.
interface imem_resp_32_if;
  import imem_resp_32_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_data;
  logic               rsp_err;
  logic               load_en;
  logic [31:0]        load_addr;
  logic [INSTR_W-1:0] load_data;

  // Responder side.
  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Fetch / boot-loader side.
  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_resp_32_resp_fifo.sv
// In-order response buffer holding {err, data}; head shown combinationally.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot the same cycle.
module resp_fifo_32
  import imem_resp_32_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_W = fifo_ptr_w(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rsp_t push_dat,
  input  logic pop,
  output rsp_t head,
  output logic empty,
  output logic full
);

  localparam int AW = PTR_W - 1;

  rsp_t             store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so reset and idle both show a clean bus.
  assign head = empty ? '0 : store[rd_ptr[AW-1:0]];

  // Pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/imem_resp_32.sv
// Instruction-memory responder: word fetch with fixed pipeline, in-order response FIFO.
// Latency: LATENCY cycles from accept to earliest rsp_valid (FIFO empty).
// Backpressure: credit-based; req_ready drops when LATENCY pipe + FIFO hold FIFO_DEPTH entries.
// Optional: define IMEM_ERR_CNT_EN to add the saturating err_count output.
module imem_resp_32
  import imem_resp_32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  imem_resp_32_if.slave      bus
`ifdef IMEM_ERR_CNT_EN
  , output logic [15:0]      err_count
`endif
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam int               PTR_W     = fifo_ptr_w(FIFO_DEPTH);
  localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [PTR_W-1:0] CREDITS   = PTR_W'(FIFO_DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH_WORDS];

  logic               accept;
  logic               pop;
  logic               push;
  logic               req_err;
  logic               load_ok;
  rsp_t               req_rsp;
  logic [PTR_W-1:0]   outstanding;
  logic [LATENCY-1:0] stage_vld;
  rsp_t               stage_dat [LATENCY];
  rsp_t               head;
  logic               fifo_empty;
  logic               fifo_full;

  // Credits come from registered state only, so no path from rsp_ready/req_valid.
  assign bus.req_ready = (outstanding < CREDITS);
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= DEPTH_IDX);
  assign load_ok = bus.load_en && (bus.load_addr[1:0] == 2'b00) &&
                   (bus.load_addr[31:2] < DEPTH_IDX);

  // Classify and read at accept; the read sees the array before a same-edge load.
  always_comb begin
    req_rsp      = '0;
    req_rsp.err  = req_err;
    req_rsp.data = req_err ? DEFAULT_WORD : mem[bus.req_addr[IDX_W+1:2]];
  end

  // Program-load port; illegal addresses are silently dropped, array never reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem[bus.load_addr[IDX_W+1:2]] <= bus.load_data;
  end

  // Valid bits of the fixed-latency pipe; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_vld <= '0;
    end else begin
      stage_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) stage_vld[i] <= stage_vld[i-1];
    end
  end

  // Pipe payload follows its valid bit; no reset needed.
  always_ff @(posedge clk) begin
    stage_dat[0] <= req_rsp;
    for (int i = 1; i < LATENCY; i++) stage_dat[i] <= stage_dat[i-1];
  end

  // Outstanding = in pipe + in FIFO; a pop returns its credit next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + PTR_W'(1);
        2'b01:   outstanding <= outstanding - PTR_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credits guarantee space; the full term only matters if that is ever violated.
  assign push = stage_vld[LATENCY-1] && (!fifo_full || pop);

  resp_fifo_32 #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (stage_dat[LATENCY-1]),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_err   = head.err;

`ifdef IMEM_ERR_CNT_EN
  // Count errored accepts, sticking at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (accept && req_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_resp_32.sv
// Self-checking bench: random + directed stimulus, scoreboard fed by a word-level memory model.
// Latency: checks accept-to-response timing on an empty FIFO.
// Backpressure: exercises credit stall, hold stability and toggling rsp_ready.
module tb_imem_resp_32;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
`ifdef IMEM_ERR_CNT_EN
  logic [15:0] err_count;
  logic [15:0] err_base;
`endif

  imem_resp_32_if bus ();

  imem_resp_32 dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef IMEM_ERR_CNT_EN
    , .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_accepts = 0;
  int          n_pops   = 0;
  exp_t        exp_q[$];
  logic [31:0] model_mem [256];
  exp_t        e_pred;
  exp_t        e_mon;
  logic        stall;
  logic [31:0] held_data;
  logic        held_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a fetch sees memory as it was before this edge's load.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.req_valid && bus.req_ready) begin
        e_pred.err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= 32'd1024);
        e_pred.data = e_pred.err ? 32'h0 : model_mem[bus.req_addr[9:2]];
        exp_q.push_back(e_pred);
        n_accepts++;
      end
      if (bus.load_en && bus.load_addr[1:0] == 2'b00 && bus.load_addr < 32'd1024)
        model_mem[bus.load_addr[9:2]] = bus.load_data;
    end
  end

  // Monitor: compares each popped response and checks stability while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("hold_data", bus.rsp_data, held_data);
        chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, held_err});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %h err %b, required no response",
                   bus.rsp_data, bus.rsp_err);
        end else begin
          e_mon = exp_q.pop_front();
          chk("rsp_data", bus.rsp_data, e_mon.data);
          chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e_mon.err});
        end
      end
      stall     = bus.rsp_valid && !bus.rsp_ready;
      held_data = bus.rsp_data;
      held_err  = bus.rsp_err;
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case (r[2:0])
      3'd6:    return {22'd0, r[15:8], r[16], 1'b1};
      3'd7:    return {r[31:11], 1'b1, r[9:2], 2'b00};
      default: return {22'd0, r[15:8], 2'b00};
    endcase
  endfunction

  task automatic drain(input string nm);
    bus.req_valid = 1'b0;
    bus.load_en   = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int acc0;
    int pop0;
    int cnt;
    int cyc;
    logic acc;
    logic [31:0] a;

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    stall         = 1'b0;
    #2;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    #20;
    reset = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
`ifdef IMEM_ERR_CNT_EN
    chk("rst_err_count", {16'b0, err_count}, 32'd0);
`endif
    tick();

    // Fill the whole array so the model never depends on unknown contents.
    for (int i = 0; i < 256; i++) load(32'(i * 4), $urandom);

    // Back-to-back fetch latency.
    load(32'h0, 32'h20080005);
    load(32'h4, 32'h21290001);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_addr  = 32'h4;
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("lat_n2_data", bus.rsp_data, 32'h20080005);
    @(negedge clk);
    chk("lat_n3_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("lat_n3_data", bus.rsp_data, 32'h21290001);
    tick();
    drain("drain_lat");

    // Misaligned and out-of-range fetches.
`ifdef IMEM_ERR_CNT_EN
    err_base = err_count;
`endif
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h2;
    tick();
    bus.req_addr  = 32'h400;
    tick();
    drain("drain_err");
`ifdef IMEM_ERR_CNT_EN
    chk("err_count_delta", {16'b0, err_count - err_base}, 32'd2);
`endif

    // Credit stall: six offered, four accepted.
    bus.rsp_ready = 1'b0;
    acc0 = n_accepts;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h40 + 32'(4 * i);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("credit_accepts", 32'(n_accepts - acc0), 32'd4);
    @(negedge clk);
    chk("credit_ready_low", {31'b0, bus.req_ready}, 32'd0);
    tick();
    repeat (3) tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("ready_before_pop", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_pop", {31'b0, bus.req_ready}, 32'd1);
    tick();
    drain("drain_credit");

    // Same-edge load and fetch returns the old word.
    load(32'h8, 32'hAAAA0000);
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h8;
    bus.load_data = 32'hBBBB0000;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    tick();
    bus.load_en   = 1'b0;
    tick();
    drain("drain_collision");

    // Reset with 3 buffered and 1 in flight.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * i);
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    chk("rst_pre_valid", {31'b0, bus.rsp_valid}, 32'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_data", bus.rsp_data, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {31'b0, bus.rsp_valid}, 32'd0);
    end
    tick();

    // Sequential stream with toggling rsp_ready, wrapping the FIFO pointers.
    pop0 = n_pops;
    cnt  = 0;
    a    = 32'h0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b1;
    for (cyc = 0; cyc < 200 && cnt < 20; cyc++) begin
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cnt++;
        a = a + 32'd4;
        bus.req_addr = a;
      end
      if (cnt == 20) bus.req_valid = 1'b0;
      bus.rsp_ready = ~bus.rsp_ready;
    end
    chk("stream_accepts", 32'(cnt), 32'd20);
    drain("drain_stream");
    chk("stream_pops", 32'(n_pops - pop0), 32'd20);

    // Random traffic with concurrent loads.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom % 2) == 0;
      bus.req_addr  = rand_addr();
      bus.load_en   = ($urandom % 4) == 0;
      bus.load_addr = rand_addr();
      bus.load_data = $urandom;
      bus.rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp_32.md
Name: imem_resp_32

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the program counter.
- Accepts word-address fetch requests through a valid/ready handshake and returns the instruction word after a fixed pipeline latency.
- Responses are buffered in a small in-order FIFO so back-pressure from the fetch side never drops a word.
- Contents are loaded through a separate program-load write port, used by the testbench and boot logic.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; word index = req_addr[31:2].
- LATENCY, 2: cycles from request accept to earliest rsp_valid; legal range 1..4.
- FIFO_DEPTH, 4: response buffer entries and maximum outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- rsp_valid  out  1  response word available at the FIFO head.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_data  out  32  instruction word; 32'h00000000 when rsp_err is 1.
- rsp_err  out  1  misaligned or out-of-range request.
- load_en  in  1  program-load write strobe.
- load_addr  in  32  byte address for the load write.
- load_data  in  32  word to store.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pipeline valids cleared, FIFO emptied, outstanding count set to 0.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - req_ready=1 from the first cycle after reset deasserts.
  - Memory array is not cleared.
  - Reset mid-operation discards every in-flight and buffered response; no partial response is ever emitted.
- Accept: a request is accepted when req_valid=1 and req_ready=1 are sampled at the same edge. req_addr is sampled only at accept.
- Credit rule:
  - outstanding = requests in the pipeline + FIFO occupancy.
  - req_ready = (outstanding < FIFO_DEPTH), decoded from registered state only.
  - There is no combinational path from rsp_ready or req_valid to req_ready.
  - A pop frees its credit in the following cycle.
- Latency:
  - A request accepted at edge N is visible at the FIFO head by cycle N+LATENCY when the FIFO was empty.
  - Otherwise it waits behind earlier responses, strictly in order.
  - With rsp_ready held at 1, throughput is one response per cycle.
- Error classification, decided at accept:
  - req_addr[1:0] != 0 gives rsp_err=1 and rsp_data=0.
  - Otherwise, word index >= DEPTH_WORDS gives rsp_err=1 and rsp_data=0.
  - Otherwise rsp_err=0 and rsp_data = the stored word.
  - An errored request still occupies one credit and one response slot.
- Output hold: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_err are held stable.
- Pop: occurs when rsp_valid=1 and rsp_ready=1.
- Full FIFO with pop in the same cycle: the pipeline output enters the FIFO in that cycle and no data is lost.
- Load writes:
  - load_en=1 writes load_data at word load_addr[31:2] at the edge.
  - Writes with load_addr[1:0] != 0 or an out-of-range index are ignored.
- Read/write collision: a fetch accepted in the same edge as a load to the same word returns the old contents. A later fetch returns the new contents.
- Pointer wrap: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are distinguished by the MSB.

Optional Feature:
- Macro: IMEM_ERR_CNT_EN.
- Defined:
  - Adds output err_count[15:0].
  - Increments once per accepted request classified as an error.
  - Saturates at 16'hFFFF.
  - Reset to 0 by the asynchronous reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - INSTR_W=32.
  - Error-free default word 32'h00000000.
  - Localparam for the FIFO pointer width, derived as clog2(FIFO_DEPTH)+1.
- One natural sub-module: resp_fifo_32, a synchronous FIFO with data+err payload, push/pop, full/empty and the same async active-low reset.
- The memory array and latency pipeline stay in imem_resp_32.

Test Plan:
- Load 0x00000000=32'h20080005 and 0x00000004=32'h21290001, then fetch both back-to-back with rsp_ready=1 -> rsp_data 32'h20080005 at cycle N+2, 32'h21290001 at N+3, rsp_err=0.
- Fetch 0x00000002, then fetch 0x00000400 with DEPTH_WORDS=256 -> two responses, each rsp_err=1 and rsp_data=0; with IMEM_ERR_CNT_EN, err_count=2.
- Hold rsp_ready=0 and issue 6 requests -> exactly 4 accepted, req_ready=0 afterwards, head data stable; raise rsp_ready -> 4 responses in address order, req_ready returns 1 the cycle after the first pop.
- Load 0x00000008=32'hAAAA0000, then in one cycle load 0x00000008=32'hBBBB0000 and fetch 0x00000008, then fetch it again -> responses 32'hAAAA0000 then 32'hBBBB0000.
- Assert reset=0 with 3 responses buffered and 1 in flight -> rsp_valid=0 immediately; after release, no stale response appears and req_ready=1.
- Stream 20 sequential fetches from 0x0 with rsp_ready toggling 1,0,1,0 -> all 20 words delivered in order with no duplicates, exercising pointer wrap.
